// File: rtl/serial_deserializer_if.sv
// Serial deserializer bus: serial input, framing controls, and the held-word
// handshake. The master drives the bit stream and acknowledge; the slave
// (the deserializer) returns the word, status flags and busy.
interface serial_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             i;   // serial data bit
    logic             e;   // bit enable
    logic             s;   // start-of-frame strobe
    logic             r;   // bit order at start: 1 = LSB-first
    logic             a;   // acknowledge of held word
    logic [WIDTH-1:0] q;   // received word
    logic             v;   // q holds an unacknowledged word
    logic             o;   // sticky overrun
    logic             b;   // frame in progress
    logic             pe;  // parity error for word in q

    modport master (output i, e, s, r, a, input q, v, o, b, pe);
    modport slave  (input i, e, s, r, a, output q, v, o, b, pe);
endinterface

// File: rtl/serial_deserializer.sv
// Serial-in/parallel-out receiver. A start strobe frames each word, a bit
// enable qualifies each bit, and the finished word sits in an output register
// behind a valid/acknowledge handshake with a sticky overrun flag.
// Optional feature: define DESER_PARITY_EN to expect an even-parity bit after
// the data bits and report pe; without it pe is constant 0.
module serial_deserializer #(
    parameter int WIDTH = 8
) (
    input logic              c,
    input logic              nrst,
    serial_deserializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr;
    logic             r_lat;
    logic [WIDTH-1:0] q_r;
    logic             v_r;
    logic             o_r;
    logic             b_r;
    logic [WIDTH-1:0] sr_shift;
    logic [WIDTH-1:0] sr_start;
    logic             last_bit;
`ifdef DESER_PARITY_EN
    logic             pe_r;
`endif

    // Next shift-register values: a mid-frame shift in the latched order, and
    // a fresh frame seeded with the start-cycle bit (if enabled) in order r.
    always_comb begin
        sr_shift = r_lat ? {bus.i, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], bus.i};
        sr_start = '0;
        if (bus.e)
            sr_start = bus.r ? {bus.i, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, bus.i};
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    // Framing FSM plus output register; a start strobe outranks everything
    // else, and a completion outranks a same-edge acknowledge.
    always_ff @(posedge c or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
            r_lat <= 1'b0;
            q_r   <= '0;
            v_r   <= 1'b0;
            o_r   <= 1'b0;
            b_r   <= 1'b0;
`ifdef DESER_PARITY_EN
            pe_r  <= 1'b0;
`endif
        end else begin
            // Acknowledge releases the held word; overridden below on completion.
            if (v_r && bus.a) begin
                v_r  <= 1'b0;
                o_r  <= 1'b0;
`ifdef DESER_PARITY_EN
                pe_r <= 1'b0;
`endif
            end

            if (bus.s) begin
                // Start (or restart) a frame; any partial word is dropped.
                state <= SHIFT;
                b_r   <= 1'b1;
                r_lat <= bus.r;
                sr    <= sr_start;
                cnt   <= bus.e ? CW'(1) : '0;
            end else begin
                case (state)
                    SHIFT: begin
                        if (bus.e) begin
                            sr <= sr_shift;
                            if (last_bit) begin
`ifdef DESER_PARITY_EN
                                // Data complete; one parity bit still to come.
                                state <= PAR;
                                cnt   <= CW'(WIDTH);
`else
                                state <= IDLE;
                                cnt   <= '0;
                                b_r   <= 1'b0;
                                q_r   <= sr_shift;
                                v_r   <= 1'b1;
                                o_r   <= o_r | (v_r & ~bus.a);
`endif
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
`ifdef DESER_PARITY_EN
                    PAR: begin
                        if (bus.e) begin
                            state <= IDLE;
                            cnt   <= '0;
                            b_r   <= 1'b0;
                            q_r   <= sr;
                            pe_r  <= (^sr) ^ bus.i;
                            v_r   <= 1'b1;
                            o_r   <= o_r | (v_r & ~bus.a);
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.q = q_r;
    assign bus.v = v_r;
    assign bus.o = o_r;
    assign bus.b = b_r;
`ifdef DESER_PARITY_EN
    assign bus.pe = pe_r;
`else
    assign bus.pe = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: directed frame table, hand-written corner
// sequences (async reset, overrun, abort) and a randomized run against a
// queue-based frame model.
module tb_serial_deserializer;
    localparam int W = 8;
`ifdef DESER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic c = 1'b0;
    logic nrst = 1'b0;
    serial_deserializer_if #(.WIDTH(W)) bus();
    serial_deserializer #(.WIDTH(W)) dut (.c(c), .nrst(nrst), .bus(bus));

    always #5 c = ~c;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: apply inputs, take the edge, settle 1 time unit after it.
    task automatic cyc(input logic s_, input logic e_, input logic i_, input logic r_, input logic a_);
        bus.s = s_; bus.e = e_; bus.i = i_; bus.r = r_; bus.a = a_;
        @(posedge c);
        #1;
    endtask

    function automatic logic exp_pe(input logic [7:0] w, input logic p);
        return PAR_EN ? ((^w) ^ p) : 1'b0;
    endfunction

    // seq[k] is the k-th bit on the wire. Optional e=0 gap cycles carry random i.
    task automatic send_frame(input logic [7:0] seq, input logic rr, input logic gap,
                              input logic par, input logic la, input logic pv);
        int nb;
        nb = PAR_EN ? W + 1 : W;
        for (int k = 0; k < nb; k++) begin
            logic bt;
            bt = (k < W) ? seq[k] : par;
            if (gap && k > 0) begin
                cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                chk("b_gap", bus.b, 1);
                chk("v_gap", bus.v, pv);
            end
            cyc(k == 0, 1'b1, bt, (k == 0) ? rr : 1'($urandom_range(0, 1)), (k == nb - 1) ? la : 1'b0);
            if (k < nb - 1) begin
                chk("b_frame", bus.b, 1);
                chk("v_hold", bus.v, pv);
            end
        end
    endtask

    typedef struct {
        logic [7:0] seq;
        logic       r;
        logic       gap;
        logic       par;
        logic [7:0] exp_q;
    } vec_t;

    vec_t tbl [8];

    // Reference model state for the random run.
    logic [7:0] mq;
    logic       mv, mo, mpe, mb, mr;
    bit         bits [$];

    initial begin
        tbl[0] = '{8'h1E, 1'b1, 1'b0, 1'b0, 8'h1E};
        tbl[1] = '{8'h1E, 1'b0, 1'b0, 1'b1, 8'h78};
        tbl[2] = '{8'h1E, 1'b1, 1'b1, 1'b0, 8'h1E};
        tbl[3] = '{8'hC3, 1'b1, 1'b0, 1'b1, 8'hC3};
        tbl[4] = '{8'h01, 1'b0, 1'b1, 1'b0, 8'h80};
        tbl[5] = '{8'h0F, 1'b0, 1'b0, 1'b1, 8'hF0};
        tbl[6] = '{8'h80, 1'b1, 1'b0, 1'b0, 8'h80};
        tbl[7] = '{8'hB2, 1'b1, 1'b1, 1'b1, 8'hB2};

        bus.s = 0; bus.e = 0; bus.i = 0; bus.r = 0; bus.a = 0;
        repeat (2) @(posedge c);
        #1;
        chk("rst_q", bus.q, 0); chk("rst_v", bus.v, 0); chk("rst_o", bus.o, 0);
        chk("rst_b", bus.b, 0); chk("rst_pe", bus.pe, 0);
        nrst = 1'b1;
        cyc(0, 0, 0, 0, 0);

        // Async reset mid-frame while an unacknowledged word is held.
        send_frame(8'h1E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_pre_v", bus.v, 1);
        cyc(1, 1, 0, 1, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        chk("t1_busy", bus.b, 1);
        #2 nrst = 1'b0;
        #1;
        chk("t1_async_q", bus.q, 0); chk("t1_async_v", bus.v, 0);
        chk("t1_async_o", bus.o, 0); chk("t1_async_b", bus.b, 0);
        #1 nrst = 1'b1;
        @(posedge c);
        #1;
        send_frame(8'h1E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_q", bus.q, 8'h1E); chk("t1_v", bus.v, 1);
        cyc(0, 0, 0, 0, 1);
        chk("t1_ack_v", bus.v, 0);

        // Directed frame table.
        for (int n = 0; n < 8; n++) begin
            send_frame(tbl[n].seq, tbl[n].r, tbl[n].gap, tbl[n].par, 1'b0, 1'b0);
            chk("tbl_q", bus.q, tbl[n].exp_q);
            chk("tbl_v", bus.v, 1);
            chk("tbl_b", bus.b, 0);
            chk("tbl_o", bus.o, 0);
            chk("tbl_pe", bus.pe, exp_pe(tbl[n].exp_q, tbl[n].par));
            cyc(0, 0, 0, 0, 1);
            chk("tbl_ack_v", bus.v, 0);
            chk("tbl_ack_pe", bus.pe, 0);
            chk("tbl_q_held", bus.q, tbl[n].exp_q);
        end

        // Overrun: second word lands while the first is unacknowledged.
        send_frame(8'h1E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_o0", bus.o, 0);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_q", bus.q, 8'hC3); chk("t5_v", bus.v, 1); chk("t5_o", bus.o, 1);
        cyc(0, 0, 0, 0, 0);
        chk("t5_o_sticky", bus.o, 1);
        cyc(0, 0, 0, 0, 1);
        chk("t5_ack_v", bus.v, 0); chk("t5_ack_o", bus.o, 0);
        // Same, but acknowledged on the completion edge: no overrun.
        send_frame(8'h1E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t5b_q", bus.q, 8'hC3); chk("t5b_v", bus.v, 1); chk("t5b_o", bus.o, 0);
        cyc(0, 0, 0, 0, 1);
        chk("t5b_ack_v", bus.v, 0);

        // Abort: 5 bits then a restart carrying 0xC3.
        cyc(1, 1, 1, 1, 0);
        for (int k = 0; k < 4; k++) cyc(0, 1, 1'($urandom_range(0, 1)), 1'b0, 0);
        chk("t6_b", bus.b, 1); chk("t6_v", bus.v, 0);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_q", bus.q, 8'hC3); chk("t6_v1", bus.v, 1); chk("t6_o", bus.o, 0);
        chk("t6_pe1", bus.pe, exp_pe(8'hC3, 1'b1));
        cyc(0, 0, 0, 0, 1);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_pe0", bus.pe, exp_pe(8'hC3, 1'b0));
        cyc(0, 0, 0, 0, 1);
        // Start strobe on the cycle that would finish the frame: no completion.
        cyc(1, 1, 1, 1, 0);
        for (int k = 1; k < W + int'(PAR_EN) - 1; k++) cyc(0, 1, 1'b1, 1'b1, 0);
        cyc(1, 1, 1, 1, 0);
        chk("t6_s_wins_v", bus.v, 0); chk("t6_s_wins_b", bus.b, 1);
        chk("t6_s_wins_q", bus.q, 8'hC3);

        // Randomized run against the frame model, from reset.
        #1 nrst = 1'b0;
        #1 nrst = 1'b1;
        mq = '0; mv = 0; mo = 0; mpe = 0; mb = 0; mr = 0;
        bits.delete();
        for (int t = 0; t < 2000; t++) begin
            logic s_, e_, i_, r_, a_, done;
            logic [7:0] word;
            s_ = ($urandom_range(0, 15) == 0);
            e_ = ($urandom_range(0, 2) != 0);
            i_ = 1'($urandom_range(0, 1));
            r_ = 1'($urandom_range(0, 1));
            a_ = ($urandom_range(0, 5) == 0);
            done = 0;
            if (s_) begin
                bits.delete();
                mr = r_;
                mb = 1;
                if (e_) bits.push_back(i_);
            end else if (mb && e_) begin
                bits.push_back(i_);
                if (bits.size() == W + int'(PAR_EN)) done = 1;
            end
            if (done) begin
                word = '0;
                for (int k = 0; k < W; k++) word[mr ? k : W - 1 - k] = bits[k];
                if (PAR_EN) mpe = (^word) ^ bits[W];
                else mpe = 1'b0;
                if (mv && !a_) mo = 1;
                mq = word;
                mv = 1;
                mb = 0;
                bits.delete();
            end else if (mv && a_) begin
                mv = 0; mo = 0; mpe = 0;
            end
            cyc(s_, e_, i_, r_, a_);
            chk("rnd_q", bus.q, mq);
            chk("rnd_v", bus.v, mv);
            chk("rnd_o", bus.o, mo);
            chk("rnd_b", bus.b, mb);
            chk("rnd_pe", bus.pe, mpe);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
